mult_div_unit: RTL and testbench

//  Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI, MTLO.

---
 rtl/mips_pkg.sv | 17 +
 rtl/md_step.sv | 40 ++++
 rtl/mult_div_unit.sv | 118 +++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, widths.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_step.sv
// One iteration of the multiply (add/shift right) or restoring divide (subtract/shift left) datapath.
import mips_pkg::*;

module md_step #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] low_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] low_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = {1'b0, acc_in} + (low_in[0] ? {1'b0, opnd} : '0);
        shifted = {acc_in, low_in[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        acc_out = '0;
        low_out = '0;
        if (is_div) begin
            // a non-negative difference always fits in WIDTH bits since rem < divisor
            if (diff[WIDTH+1:WIDTH] == 2'b00) begin
                acc_out = diff[WIDTH-1:0];
                low_out = {low_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = shifted[WIDTH-1:0];
                low_out = {low_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = sum[WIDTH:1];
            low_out = {sum[0], low_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: magnitude datapath for WIDTH cycles, then one sign-fix cycle.
//  state | meaning
//  IDLE  | waiting for start; MTHI/MTLO accepted here
//  RUN   | one shift/add or shift/subtract per cycle, WIDTH cycles
//  FIX   | sign-correct and write hi/lo, pulse done
import mips_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_low;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .low_in  (low),
        .opnd    (opnd),
        .acc_out (step_acc),
        .low_out (step_low)
    );

    always_comb begin
        a_mag    = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag    = (op[0] && b[WIDTH-1]) ? -b : b;
        prod_fix = neg_q ? -{acc, low} : {acc, low};
        if (is_div) begin
            hi_fix = neg_r ? -acc : acc;
            // divide by zero: restoring loop leaves rem = dividend, quotient forced to all ones
            lo_fix = (opnd == '0) ? '1 : (neg_q ? -low : low);
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            low    <= '0;
            opnd   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= op[0] & a[WIDTH-1];
                        acc    <= '0;
                        low    <= op[1] ? a_mag : b_mag;
                        opnd   <= op[1] ? b_mag : a_mag;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                RUN: begin
                    acc <= step_acc;
                    low <= step_low;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic HI/LO model.
import mips_pkg::*;

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        eh = '0;
        el = '0;
        case (o)
            MD_MULTU: begin
                p  = {32'b0, x} * {32'b0, y};
                eh = p[63:32];
                el = p[31:0];
            end
            MD_MULT: begin
                p  = sx * sy;
                eh = p[63:32];
                el = p[31:0];
            end
            MD_DIVU: begin
                if (y == 0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                end else begin
                    el = x / y;
                    eh = x % y;
                end
            end
            default: begin
                if (y == 0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                end else begin
                    p  = sx / sy;
                    el = p[31:0];
                    p  = sx % sy;
                    eh = p[31:0];
                end
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Launch at a negedge, wait for done (bounded); optional disturbance (start+mthi) at cycle 'disturb'.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int disturb, input string tag);
        logic [31:0] eh, el, ph, pl;
        int          cyc, busy_cnt;
        bit          held;
        model(o, x, y, eh, el);
        ph = hi;
        pl = lo;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        held = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (hi !== ph || lo !== pl) held = 1'b0;
            if (cyc == disturb) begin
                op = MD_DIVU;
                a = 32'hDEAD;
                b = 32'd3;
                start = 1'b1;
                mthi = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            mthi = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " hilo_held"}, 64'(held), 64'd1);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        bit          seen;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        do_op(MD_MULT, -32'sd3, 32'd5, -1, "mult_neg");
        do_op(MD_DIV, -32'sd7, 32'd2, -1, "div_neg");
        do_op(MD_DIVU, 32'd100, 32'd0, -1, "divu_zero");
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        do_op(MD_DIV, -32'sd9, 32'd0, -1, "div_zero_neg");
        do_op(MD_MULTU, 32'd6, 32'd7, 10, "busy_ignore");
        do_op(MD_DIVU, 32'd9, 32'd3, -1, "back_to_back");

        // moves from IDLE
        seen = 1'b0;
        mthi = 1'b1;
        a = 32'h1234;
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
        mthi = 1'b0;
        mtlo = 1'b1;
        a = 32'h5678;
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
        mtlo = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234);
        check("mtlo lo", 64'(lo), 64'h5678);
        check("move no_done", 64'(seen), 64'd0);
        mthi = 1'b1;
        mtlo = 1'b1;
        a = 32'hCAFE;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo hi", 64'(hi), 64'hCAFE);
        check("mthi_mtlo lo", 64'(lo), 64'hCAFE);
        mtlo = 1'b1;
        do_op(MD_MULTU, 32'd2, 32'd3, -1, "start_beats_mtlo");

        // async reset at iteration 15
        op = MD_MULTU;
        a = 32'h0012_3456;
        b = 32'h0000_0777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("midrst no_stale", 64'(seen), 64'd0);
        do_op(MD_MULTU, 32'd2, 32'd3, -1, "post_rst");

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(1, 31);
            do_op(ro, rx, ry, -1, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
